// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: drives the PC register, runs the imem request/response
// handshake, hands instructions to decode and handles redirects and memory timeouts.
module fetch_sequencer #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_we,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            decode_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misaligned,
  output logic            fetch_fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misaligned_q, misaligned_d;
  logic            fetch_fault_q, fetch_fault_d;

  logic [CNT_W-1:0] cnt_inc;
  logic            timeout;
  logic [XLEN-1:0] redirect_aligned;

  // The counter saturates at the limit so a late redirect into DRAIN cannot wrap it.
  assign cnt_inc          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout          = (cnt_inc == CNT_MAX);
  assign redirect_aligned = {redirect_target[XLEN-1:2], 2'b00};
  assign imem_req_addr    = pc_cur;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    instr_valid_d  = instr_valid_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    misaligned_d   = 1'b0;
    fetch_fault_d  = fetch_fault_q;
    pc_we          = 1'b0;
    pc_next        = pc_plus4;
    imem_req_valid = 1'b0;

    if (redirect_valid && state_q != S_FAULT) begin
      misaligned_d = |redirect_target[1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
        end
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
          // A request accepted alongside a redirect fetches the old PC; drain it.
          if (imem_req_ready) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
          state_d = imem_resp_valid ? S_REQ : S_DRAIN;
        end else if (imem_resp_valid) begin
          instr_d       = imem_resp_data;
          instr_pc_d    = pc_cur;
          instr_valid_d = 1'b1;
          pc_we         = 1'b1;
          state_d       = S_HOLD;
        end else if (timeout) begin
          fetch_fault_d = 1'b1;
          state_d       = S_FAULT;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_next = redirect_aligned;
        end
        if (imem_resp_valid) begin
          state_d = S_REQ;
        end else if (timeout) begin
          fetch_fault_d = 1'b1;
          state_d       = S_FAULT;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_we         = 1'b1;
          pc_next       = redirect_aligned;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (decode_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      S_FAULT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      misaligned_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      misaligned_q  <= misaligned_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misaligned  = misaligned_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a PC register model plus hand-driven imem and
// decode sides, stepping the handshake cycle by cycle with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misaligned;
  logic        fetch_fault;

  int checks = 0;
  int passes = 0;

  fetch_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_reg),
    .pc_plus4        (pc_plus4),
    .pc_next         (pc_next),
    .pc_we           (pc_we),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .decode_ready    (decode_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misaligned      (misaligned),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer drives.
  always @(posedge clk) begin
    if (rst) pc_reg <= 32'h0;
    else if (pc_we) pc_reg <= pc_next;
  end
  assign pc_plus4 = pc_reg + 32'd4;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic dr, input logic redir, input logic [31:0] tgt);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    decode_ready    = dr;
    redirect_valid  = redir;
    redirect_target = tgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_misaligned", misaligned, 0);
    checkOutput("rst_fault", fetch_fault, 0);
    checkOutput("rst_req_valid", imem_req_valid, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_req_valid", imem_req_valid, 0);
    tick();

    // Zero-wait memory with decode always ready: REQ, WAIT, HOLD per instruction.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("seq_req_valid", imem_req_valid, 1);
      checkOutput("seq_req_addr", imem_req_addr, 32'(4 * k));
      checkOutput("seq_req_pc_we", pc_we, 0);
      tick();
      applyStimulus(0, 1, 32'h1000_0000 + 32'(k), 0, 0, 32'h0);
      checkOutput("seq_wait_pc_we", pc_we, 1);
      checkOutput("seq_wait_pc_next", pc_next, 32'(4 * k + 4));
      checkOutput("seq_wait_valid", instr_valid, 0);
      tick();
      applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
      checkOutput("seq_hold_valid", instr_valid, 1);
      checkOutput("seq_hold_instr", instr, 32'h1000_0000 + 32'(k));
      checkOutput("seq_hold_pc", instr_pc, 32'(4 * k));
      checkOutput("seq_hold_req", imem_req_valid, 0);
      checkOutput("seq_hold_pc_we", pc_we, 0);
      tick();
    end

    // Decode stalls for five cycles in HOLD.
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("stall_req_addr", imem_req_addr, 32'hC);
    tick();
    applyStimulus(0, 1, 32'hABCD_0003, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("stall_valid", instr_valid, 1);
      checkOutput("stall_instr", instr, 32'hABCD_0003);
      checkOutput("stall_pc", instr_pc, 32'hC);
      checkOutput("stall_req", imem_req_valid, 0);
      checkOutput("stall_pc_we", pc_we, 0);
      tick();
    end
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("stall_next_req", imem_req_valid, 1);
    checkOutput("stall_next_addr", imem_req_addr, 32'h10);
    tick();

    // Redirect to 0x100 during WAIT; the old response turns up two cycles later.
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h100);
    checkOutput("wredir_pc_we", pc_we, 1);
    checkOutput("wredir_pc_next", pc_next, 32'h100);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("wredir_misaligned", misaligned, 0);
    checkOutput("wredir_drain_req", imem_req_valid, 0);
    tick();
    applyStimulus(0, 1, 32'hDEAD_DEAD, 0, 0, 32'h0);
    checkOutput("wredir_drop_pc_we", pc_we, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("wredir_no_valid", instr_valid, 0);
    checkOutput("wredir_req", imem_req_valid, 1);
    checkOutput("wredir_addr", imem_req_addr, 32'h100);

    // Misaligned redirect in REQ while the request is accepted.
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h202);
    checkOutput("rredir_pc_we", pc_we, 1);
    checkOutput("rredir_pc_next", pc_next, 32'h200);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("rredir_misaligned", misaligned, 1);
    checkOutput("rredir_drain_req", imem_req_valid, 0);
    tick();
    applyStimulus(0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0);
    checkOutput("rredir_mis_pulse", misaligned, 0);
    checkOutput("rredir_drop_pc_we", pc_we, 0);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("rredir_req", imem_req_valid, 1);
    checkOutput("rredir_addr", imem_req_addr, 32'h200);
    checkOutput("rredir_no_valid", instr_valid, 0);
    tick();

    // Memory goes silent: eight WAIT cycles, then a sticky fault.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("to_no_fault", fetch_fault, 0);
      tick();
    end
    checkOutput("to_fault", fetch_fault, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 32'h0, 1, 1, 32'h303);
      checkOutput("fault_pc_we", pc_we, 0);
      checkOutput("fault_req", imem_req_valid, 0);
      checkOutput("fault_valid", instr_valid, 0);
      tick();
      checkOutput("fault_sticky", fetch_fault, 1);
      checkOutput("fault_mis", misaligned, 0);
    end
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    checkOutput("fault_rst_clear", fetch_fault, 0);
    rst = 1'b0;
    #1;
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("restart_req", imem_req_valid, 1);
    checkOutput("restart_addr", imem_req_addr, 32'h0);
    tick();

    // Reset lands in HOLD with a response on the bus.
    applyStimulus(0, 1, 32'h5555_0000, 0, 0, 32'h0);
    tick();
    checkOutput("hrst_pre_valid", instr_valid, 1);
    rst = 1'b1;
    applyStimulus(0, 1, 32'h6666_0000, 0, 0, 32'h0);
    tick();
    checkOutput("hrst_valid", instr_valid, 0);
    checkOutput("hrst_instr", instr, 0);
    checkOutput("hrst_fault", fetch_fault, 0);
    checkOutput("hrst_idle_req", imem_req_valid, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    tick();

    // Redirect in HOLD beats decode_ready.
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 1, 32'h7777_0000, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h41);
    checkOutput("hredir_pc_we", pc_we, 1);
    checkOutput("hredir_pc_next", pc_next, 32'h40);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("hredir_valid", instr_valid, 0);
    checkOutput("hredir_mis", misaligned, 1);
    checkOutput("hredir_addr", imem_req_addr, 32'h40);
    checkOutput("hredir_req", imem_req_valid, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
